// File: rtl/write_pack_buffer_if.sv
// Handshake bundle for write_pack_buffer: element write side and line read side.
// Ports: wrreq/wdata/last/flush/full (write), rdreq/rdata/rcount/rlast/empty (read).
interface write_pack_buffer_if #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64
);
    logic                  wrreq;
    logic [WIDTH-1:0]      wdata;
    logic                  last;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  rdreq;
    logic [FULL_WIDTH-1:0] rdata;
    logic [7:0]            rcount;
    logic                  rlast;

    modport master (
        output wrreq, wdata, last, flush, rdreq,
        input  full, empty, rdata, rcount, rlast
    );

    modport slave (
        input  wrreq, wdata, last, flush, rdreq,
        output full, empty, rdata, rcount, rlast
    );
endinterface

// File: rtl/write_pack_buffer.sv
// Packs WIDTH-bit elements MSB-first into FULL_WIDTH-bit lines, queued in a line FIFO.
// Ports: clk, rst (sync, active-high), bus (slave modport: element in, line out).
module write_pack_buffer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int LOG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    write_pack_buffer_if.slave    bus
);
    localparam int MAX_ELEMS = FULL_WIDTH / WIDTH;
    localparam int DEPTH     = 1 << LOG_DEPTH;

    localparam logic [7:0]         LAST_SLOT = 8'(MAX_ELEMS - 1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = 1;
    localparam logic [LOG_DEPTH:0]   OCC_ONE = 1;

    logic [FULL_WIDTH-1:0] mem_line [DEPTH];
    logic [7:0]            mem_cnt  [DEPTH];
    logic                  mem_last [DEPTH];

    logic [FULL_WIDTH-1:0] asm_q;
    logic [FULL_WIDTH-1:0] asm_ins;
    logic [7:0]            fill;
    logic [LOG_DEPTH-1:0]  wrline;
    logic [LOG_DEPTH-1:0]  rdline;
    logic [LOG_DEPTH:0]    lines;

    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  close_el;
    logic                  flush_push;
    logic                  push;
    logic                  pop;
    logic [FULL_WIDTH-1:0] push_line;
    logic [7:0]            push_cnt;
    logic                  push_last;

    assign full  = lines[LOG_DEPTH];
    assign empty = (lines == '0);

    assign accept     = bus.wrreq && !full;
    assign close_el   = accept &&
                        (fill == LAST_SLOT || bus.last || bus.flush);
    // A bare flush only closes a non-empty line; empty lines never get queued.
    assign flush_push = bus.flush && !bus.wrreq && fill != 8'd0 && !full;
    assign push       = close_el || flush_push;
    assign pop        = bus.rdreq && !empty;

    // Slot k sits at the top-down k-th WIDTH field so the first element is MSB-aligned.
    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < MAX_ELEMS; i++) begin
            if (fill == 8'(i)) begin
                asm_ins[FULL_WIDTH-1-i*WIDTH -: WIDTH] = bus.wdata;
            end
        end
    end

    always_comb begin
        push_line = asm_ins;
        push_cnt  = fill + 8'd1;
        push_last = bus.last || bus.flush;
        if (flush_push) begin
            push_line = asm_q;
            push_cnt  = fill;
            push_last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lines  <= '0;
            wrline <= '0;
            rdline <= '0;
            fill   <= '0;
            asm_q  <= '0;
        end else begin
            if (push) begin
                wrline <= wrline + PTR_ONE;
            end
            if (pop) begin
                rdline <= rdline + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   lines <= lines + OCC_ONE;
                2'b01:   lines <= lines - OCC_ONE;
                default: lines <= lines;
            endcase
            if (accept) begin
                if (close_el) begin
                    asm_q <= '0;
                    fill  <= '0;
                end else begin
                    asm_q <= asm_ins;
                    fill  <= fill + 8'd1;
                end
            end else if (flush_push) begin
                asm_q <= '0;
                fill  <= '0;
            end
        end
    end

    // Line storage is left unreset; stale entries are hidden behind empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_line[wrline] <= push_line;
            mem_cnt[wrline]  <= push_cnt;
            mem_last[wrline] <= push_last;
        end
    end

    assign bus.full   = full;
    assign bus.empty  = empty;
    assign bus.rdata  = empty ? '0   : mem_line[rdline];
    assign bus.rcount = empty ? 8'd0 : mem_cnt[rdline];
    assign bus.rlast  = empty ? 1'b0 : mem_last[rdline];
endmodule

// File: tb/tb_write_pack_buffer.sv
// Scoreboard bench for write_pack_buffer: stimulus queues expected lines,
// a negedge monitor compares each popped head line against the queue.
module tb_write_pack_buffer;
    localparam int FW = 512;
    localparam int W  = 64;

    typedef struct {
        logic [FW-1:0] line;
        logic [7:0]    cnt;
        logic          lst;
    } exp_t;

    logic clk;
    logic rst;

    write_pack_buffer_if #(.FULL_WIDTH(FW), .WIDTH(W)) bus ();

    write_pack_buffer #(
        .FULL_WIDTH(FW),
        .WIDTH(W),
        .LOG_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t          exp_q [$];
    int            n_pass = 0;
    int            n_tot  = 0;
    logic [FW-1:0] m_asm  = '0;
    int            m_fill = 0;
    int            m_lines = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: a pop happens at the next posedge when rdreq && !empty.
    always @(negedge clk) begin
        if (!rst && bus.rdreq && bus.empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_line", {504'd0, bus.rcount}, '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("line_data", bus.rdata, e.line);
                chk("line_count", FW'(bus.rcount), FW'(e.cnt));
                chk("line_last", FW'(bus.rlast), FW'(e.lst));
            end
        end
    end

    task automatic cyc(input bit wr, input logic [W-1:0] d, input bit l,
                       input bit f, input bit rd);
        bit   m_full;
        bit   pushed;
        bit   pop;
        exp_t e;
        m_full = (m_lines == 16);
        pushed = 1'b0;
        pop    = rd && (m_lines != 0);
        bus.wrreq = wr;
        bus.wdata = d;
        bus.last  = l;
        bus.flush = f;
        bus.rdreq = rd;
        if (wr && !m_full) begin
            m_asm[FW-1-m_fill*W -: W] = d;
            if (m_fill == 7 || l || f) begin
                e.line = m_asm;
                e.cnt  = 8'(m_fill + 1);
                e.lst  = l || f;
                pushed = 1'b1;
                m_asm  = '0;
                m_fill = 0;
            end else begin
                m_fill++;
            end
        end else if (f && !wr && m_fill != 0 && !m_full) begin
            e.line = m_asm;
            e.cnt  = 8'(m_fill);
            e.lst  = 1'b1;
            pushed = 1'b1;
            m_asm  = '0;
            m_fill = 0;
        end
        @(posedge clk);
        #1;
        if (pushed) exp_q.push_back(e);
        m_lines = m_lines + int'(pushed) - int'(pop);
        bus.wrreq = 1'b0;
        bus.last  = 1'b0;
        bus.flush = 1'b0;
        bus.rdreq = 1'b0;
        chk("full_flag", FW'(bus.full), FW'(m_lines == 16));
        chk("empty_flag", FW'(bus.empty), FW'(m_lines == 0));
    endtask

    task automatic wr_el(input logic [W-1:0] d, input bit l = 1'b0,
                         input bit f = 1'b0);
        cyc(1'b1, d, l, f, 1'b0);
    endtask

    task automatic rd_ln();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_asm   = '0;
        m_fill  = 0;
        m_lines = 0;
        chk("rst_empty", FW'(bus.empty), FW'(1));
        chk("rst_full", FW'(bus.full), FW'(0));
        chk("rst_rdata", bus.rdata, '0);
        chk("rst_rcount", FW'(bus.rcount), FW'(0));
        chk("rst_rlast", FW'(bus.rlast), FW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.wrreq = 1'b0;
        bus.wdata = '0;
        bus.last  = 1'b0;
        bus.flush = 1'b0;
        bus.rdreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // natural fill
        for (int i = 1; i <= 8; i++) wr_el(64'(i));
        chk("nat_top", FW'(bus.rdata[511:448]), FW'(64'h1));
        chk("nat_bot", FW'(bus.rdata[63:0]), FW'(64'h8));
        chk("nat_cnt", FW'(bus.rcount), FW'(8));
        chk("nat_last", FW'(bus.rlast), FW'(0));
        rd_ln();
        chk("nat_drained", bus.rdata, '0);

        // early close on last
        wr_el(64'hA);
        wr_el(64'hB);
        wr_el(64'hC, 1'b1);
        chk("early_top", FW'(bus.rdata[511:448]), FW'(64'hA));
        chk("early_s2", FW'(bus.rdata[383:320]), FW'(64'hC));
        chk("early_tail", FW'(bus.rdata[319:0]), '0);
        chk("early_cnt", FW'(bus.rcount), FW'(3));
        chk("early_last", FW'(bus.rlast), FW'(1));
        rd_ln();

        // flush on an empty assembly register pushes nothing
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_nop", FW'(bus.empty), FW'(1));

        for (int i = 0; i < 5; i++) wr_el(64'h50 + 64'(i));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush5_cnt", FW'(bus.rcount), FW'(5));
        chk("flush5_last", FW'(bus.rlast), FW'(1));
        rd_ln();

        for (int i = 0; i < 5; i++) wr_el(64'h60 + 64'(i));
        wr_el(64'h65, 1'b0, 1'b1);
        chk("flush6_cnt", FW'(bus.rcount), FW'(6));
        chk("flush6_s5", FW'(bus.rdata[191:128]), FW'(64'h65));
        rd_ln();

        // fill all 16 lines
        for (int i = 0; i < 128; i++) wr_el(64'h100 + 64'(i));
        chk("full_set", FW'(bus.full), FW'(1));
        wr_el(64'hDEAD);
        cyc(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b1);
        chk("full_clr", FW'(bus.full), FW'(0));
        for (int i = 0; i < 8; i++) wr_el(64'h900 + 64'(i));
        chk("full_again", FW'(bus.full), FW'(1));
        for (int i = 0; i < 16; i++) rd_ln();
        chk("drain_empty", FW'(bus.empty), FW'(1));

        // push and pop in the same cycle with one line queued
        for (int i = 0; i < 8; i++) wr_el(64'h200 + 64'(i));
        for (int i = 0; i < 7; i++) wr_el(64'h300 + 64'(i));
        cyc(1'b1, 64'h307, 1'b0, 1'b0, 1'b1);
        chk("simul_empty", FW'(bus.empty), FW'(0));
        chk("simul_head", FW'(bus.rdata[511:448]), FW'(64'h300));
        rd_ln();

        // reset mid-line
        for (int i = 0; i < 4; i++) wr_el(64'h400 + 64'(i));
        do_reset();
        for (int i = 0; i < 8; i++) wr_el(64'h11 + 64'(i));
        chk("clean_top", FW'(bus.rdata[511:448]), FW'(64'h11));
        chk("clean_bot", FW'(bus.rdata[63:0]), FW'(64'h18));
        chk("clean_cnt", FW'(bus.rcount), FW'(8));
        rd_ln();

        repeat (3) @(posedge clk);
        chk("queue_drained", FW'(exp_q.size()), FW'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
